mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter bit_size, default 32, meaning address/data width.
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning max cycles waiting for M_ack before abort.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- IF_req, input, 1: instruction fetch request; held until IF_ready.
- IF_addr, input, bit_size: fetch address.
- IF_cancel, input, 1: flush of the fetch in progress.
- IF_ready, output, 1: one-cycle fetch-done pulse.
- IF_rdata, output, bit_size: fetched word.
- MEM_req, input, 1: data access request; held until MEM_ready.
- MEM_we, input, 1: data write enable.
- MEM_addr, input, bit_size: data address.
- MEM_wdata, input, bit_size: data write word.
- MEM_ready, output, 1: one-cycle data-done pulse.
- MEM_rdata, output, bit_size: data read word.
- M_en, output, 1: memory access strobe.
- M_we, output, 1: memory write enable.
- M_addr, output, bit_size: memory address.
- M_wdata, output, bit_size: memory write word.
- M_rdata, input, bit_size: memory read word.
- M_ack, input, 1: memory completion, one cycle.
- Stall, output, 1: freezes PC and all pipeline registers.
- Err, output, 1: sticky timeout flag.

Function
REQ-005 SHALL implement FSM states IDLE, SERVE_IF, SERVE_MEM.
REQ-006 In IDLE, SHALL grant on eligible requests:
- Only MEM eligible -> SERVE_MEM; only IF eligible -> SERVE_IF.
- Both eligible -> grant the requester not served last (last_grant register; reset value = IF, so MEM wins first tie).
REQ-007 A requester SHALL be ineligible in any cycle its ready output is high.
REQ-008 On grant, SHALL latch address, we and wdata (we=0 for IF). From the next cycle until M_ack, SHALL drive M_en=1 and M_we/M_addr/M_wdata from the latched values.
REQ-009 On the M_ack cycle, SHALL register M_rdata into the served requester's rdata, drop M_en, and return to IDLE.
REQ-010 In the cycle after M_ack, SHALL pulse the served requester's ready for exactly one cycle.
REQ-011 rdata SHALL hold until that requester's next completion. MEM writes SHALL leave MEM_rdata unchanged.
REQ-012 If IF_cancel is high in any SERVE_IF cycle, the transaction SHALL still complete on M_ack, but IF_ready and the IF_rdata update SHALL be suppressed.
REQ-013 A wait counter SHALL clear on grant and increment each SERVE cycle without M_ack. When it reaches TIMEOUT, SHALL:
- return to IDLE and drop M_en;
- set Err (sticky until rst);
- pulse the served ready with rdata = 0.
REQ-014 M_ack in IDLE SHALL be ignored.
REQ-015 Stall SHALL equal (IF_req & ~IF_ready & ~IF_cancel) | (MEM_req & ~MEM_ready), combinationally.
REQ-016 Best-case latency SHALL be 1 grant cycle + memory latency + 1 ready cycle.

Reset
REQ-017 rst SHALL force state IDLE, M_en=0, M_we=0, M_addr=0, M_wdata=0, IF_ready=0, MEM_ready=0, IF_rdata=0, MEM_rdata=0, Err=0, wait counter=0, last_grant=IF.
REQ-018 rst during SERVE SHALL abandon the transaction with no ready pulse; a late M_ack SHALL be ignored.

Structure
REQ-019 SHALL put state encoding (2 bits: IDLE=0, SERVE_IF=1, SERVE_MEM=2) and the grant-ID constants in shared package mem_arb_pkg.
REQ-020 SHALL place the timeout counter in sub-module arb_wdog (inputs clear, enable; output expired).

Verification
REQ-021 Single fetch: IF_req, IF_addr=0x40, M_ack 3 cycles after M_en rises with M_rdata=0x8C220004 -> IF_ready pulses once the cycle after ack, IF_rdata=0x8C220004, Stall high until that pulse.
REQ-022 Collision after reset: IF_req and MEM_req both rise in one cycle -> MEM served first, then IF, with no IDLE gap beyond one cycle. Repeated ties -> grants alternate.
REQ-023 Write: MEM_we=1, MEM_addr=0x100, MEM_wdata=0xDEADBEEF -> M_we=1, M_wdata=0xDEADBEEF while M_en high, MEM_rdata unchanged, MEM_ready pulses once.
REQ-024 Cancel: IF_cancel pulses in a mid-SERVE_IF cycle -> no IF_ready, IF_rdata keeps its old value, next request granted normally.
REQ-025 Timeout: no M_ack for 15 cycles -> Err=1, ready pulse with rdata=0, M_en=0. A subsequent normal access completes with Err still 1.
REQ-026 Reset mid-access: rst asserted in SERVE_MEM, then M_ack -> all outputs at reset values, no MEM_ready.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the instruction/data memory port arbiter:
// FSM state encoding, grant identifiers and the idle-state grant decision.
package mem_arb_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] STATE_IDLE      = 2'd0;
    localparam logic [STATE_W-1:0] STATE_SERVE_IF  = 2'd1;
    localparam logic [STATE_W-1:0] STATE_SERVE_MEM = 2'd2;

    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

    // On a tie the requester that was not served last wins.
    function automatic logic [STATE_W-1:0] pick_grant(
        input logic if_elig,
        input logic mem_elig,
        input logic last_grant
    );
        logic [STATE_W-1:0] nxt;
        nxt = STATE_IDLE;
        if (if_elig && mem_elig) begin
            nxt = (last_grant == GNT_IF) ? STATE_SERVE_MEM : STATE_SERVE_IF;
        end else if (mem_elig) begin
            nxt = STATE_SERVE_MEM;
        end else if (if_elig) begin
            nxt = STATE_SERVE_IF;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/arb_wdog.sv
// Wait counter for an outstanding memory access; flags the cycle in which
// the count of ack-less serve cycles reaches TIMEOUT.
module arb_wdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    assign expired = enable && (count == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between instruction fetch and data access,
// with round-robin tie breaking, fetch cancel and a sticky access timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned bit_size = 32,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                IF_req,
    input  logic [bit_size-1:0] IF_addr,
    input  logic                IF_cancel,
    output logic                IF_ready,
    output logic [bit_size-1:0] IF_rdata,
    input  logic                MEM_req,
    input  logic                MEM_we,
    input  logic [bit_size-1:0] MEM_addr,
    input  logic [bit_size-1:0] MEM_wdata,
    output logic                MEM_ready,
    output logic [bit_size-1:0] MEM_rdata,
    output logic                M_en,
    output logic                M_we,
    output logic [bit_size-1:0] M_addr,
    output logic [bit_size-1:0] M_wdata,
    input  logic [bit_size-1:0] M_rdata,
    input  logic                M_ack,
    output logic                Stall,
    output logic                Err
);

    logic [STATE_W-1:0]  state, state_d;
    logic                last_grant, last_grant_d;
    logic                cancel_q, cancel_d;
    logic                m_en_d, m_we_d;
    logic [bit_size-1:0] m_addr_d, m_wdata_d;
    logic                if_ready_d, mem_ready_d;
    logic [bit_size-1:0] if_rdata_d, mem_rdata_d;
    logic                err_d;
    logic                if_elig, mem_elig;
    logic                wd_clear, wd_enable, wd_expired;

    // A requester whose ready is pulsing is finishing and must not be re-granted.
    assign if_elig   = IF_req  && !IF_ready;
    assign mem_elig  = MEM_req && !MEM_ready;
    assign wd_enable = ((state == STATE_SERVE_IF) || (state == STATE_SERVE_MEM)) && !M_ack;

    assign Stall = (IF_req && !IF_ready && !IF_cancel) || (MEM_req && !MEM_ready);

    arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        cancel_d     = cancel_q;
        m_en_d       = M_en;
        m_we_d       = M_we;
        m_addr_d     = M_addr;
        m_wdata_d    = M_wdata;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
        if_rdata_d   = IF_rdata;
        mem_rdata_d  = MEM_rdata;
        err_d        = Err;
        wd_clear     = 1'b0;

        case (state)
            STATE_IDLE: begin
                cancel_d = 1'b0;
                state_d  = pick_grant(if_elig, mem_elig, last_grant);
                if (state_d == STATE_SERVE_MEM) begin
                    last_grant_d = GNT_MEM;
                    wd_clear     = 1'b1;
                    m_en_d       = 1'b1;
                    m_we_d       = MEM_we;
                    m_addr_d     = MEM_addr;
                    m_wdata_d    = MEM_wdata;
                end else if (state_d == STATE_SERVE_IF) begin
                    last_grant_d = GNT_IF;
                    wd_clear     = 1'b1;
                    m_en_d       = 1'b1;
                    m_we_d       = 1'b0;
                    m_addr_d     = IF_addr;
                    m_wdata_d    = '0;
                end
            end

            STATE_SERVE_IF: begin
                // A flushed fetch still drains the memory, but reports nothing.
                cancel_d = cancel_q || IF_cancel;
                if (M_ack || wd_expired) begin
                    state_d = STATE_IDLE;
                    m_en_d  = 1'b0;
                    if (!M_ack) begin
                        err_d = 1'b1;
                    end
                    if (!cancel_d) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = M_ack ? M_rdata : '0;
                    end
                end
            end

            STATE_SERVE_MEM: begin
                if (M_ack) begin
                    state_d     = STATE_IDLE;
                    m_en_d      = 1'b0;
                    mem_ready_d = 1'b1;
                    if (!M_we) begin
                        mem_rdata_d = M_rdata;
                    end
                end else if (wd_expired) begin
                    state_d     = STATE_IDLE;
                    m_en_d      = 1'b0;
                    err_d       = 1'b1;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = '0;
                end
            end

            default: begin
                state_d = STATE_IDLE;
                m_en_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STATE_IDLE;
            last_grant <= GNT_IF;
            cancel_q   <= 1'b0;
            M_en       <= 1'b0;
            M_we       <= 1'b0;
            M_addr     <= '0;
            M_wdata    <= '0;
            IF_ready   <= 1'b0;
            MEM_ready  <= 1'b0;
            IF_rdata   <= '0;
            MEM_rdata  <= '0;
            Err        <= 1'b0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            cancel_q   <= cancel_d;
            M_en       <= m_en_d;
            M_we       <= m_we_d;
            M_addr     <= m_addr_d;
            M_wdata    <= m_wdata_d;
            IF_ready   <= if_ready_d;
            MEM_ready  <= mem_ready_d;
            IF_rdata   <= if_rdata_d;
            MEM_rdata  <= mem_rdata_d;
            Err        <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_mem_port_arbiter;

    localparam int TMO = 15;

    logic        clk;
    logic        rst;
    logic        IF_req, IF_cancel, IF_ready;
    logic [31:0] IF_addr, IF_rdata;
    logic        MEM_req, MEM_we, MEM_ready;
    logic [31:0] MEM_addr, MEM_wdata, MEM_rdata;
    logic        M_en, M_we, M_ack, Stall, Err;
    logic [31:0] M_addr, M_wdata, M_rdata;

    mem_port_arbiter #(
        .bit_size (32),
        .TIMEOUT  (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .IF_req    (IF_req),
        .IF_addr   (IF_addr),
        .IF_cancel (IF_cancel),
        .IF_ready  (IF_ready),
        .IF_rdata  (IF_rdata),
        .MEM_req   (MEM_req),
        .MEM_we    (MEM_we),
        .MEM_addr  (MEM_addr),
        .MEM_wdata (MEM_wdata),
        .MEM_ready (MEM_ready),
        .MEM_rdata (MEM_rdata),
        .M_en      (M_en),
        .M_we      (M_we),
        .M_addr    (M_addr),
        .M_wdata   (M_wdata),
        .M_rdata   (M_rdata),
        .M_ack     (M_ack),
        .Stall     (Stall),
        .Err       (Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C220004 : (a ^ 32'hA5A50000);
    endfunction

    // ---------------- memory responder ----------------
    int ack_delay = 1;
    int en_cnt    = 0;
    bit stray_req = 1'b0;

    initial begin
        M_ack   = 1'b0;
        M_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (M_ack) begin
                M_ack  = 1'b0;
                en_cnt = 0;
            end else if (stray_req) begin
                M_ack     = 1'b1;
                M_rdata   = 32'h0BAD0BAD;
                stray_req = 1'b0;
            end else if (M_en) begin
                en_cnt++;
                if (en_cnt == ack_delay + 1) begin
                    M_ack   = 1'b1;
                    M_rdata = mem_word(M_addr);
                end
            end else begin
                en_cnt = 0;
            end
        end
    end

    // ---------------- reference model (requester 0 = IF, 1 = MEM) ----------------
    int          m_who;
    int          m_wait;
    int          m_pick;
    bit          m_cancel, m_last_mem, m_done, m_tout, m_ei, m_em, m_we;
    bit          m_rdy [2];
    bit          m_nrdy [2];
    logic [31:0] m_rdata [2];
    logic [31:0] m_addr, m_wdata;
    bit          m_err;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_who = -1; m_wait = 0; m_cancel = 0; m_last_mem = 0; m_err = 0;
                m_rdy[0] = 0; m_rdy[1] = 0; m_rdata[0] = '0; m_rdata[1] = '0;
            end else begin
                m_nrdy[0] = 0; m_nrdy[1] = 0;
                if (m_who < 0) begin
                    m_ei   = IF_req  && !m_rdy[0];
                    m_em   = MEM_req && !m_rdy[1];
                    m_pick = -1;
                    if (m_ei && m_em) m_pick = m_last_mem ? 0 : 1;
                    else if (m_em)    m_pick = 1;
                    else if (m_ei)    m_pick = 0;
                    if (m_pick >= 0) begin
                        m_who      = m_pick;
                        m_last_mem = (m_pick == 1);
                        m_wait     = 0;
                        m_cancel   = 0;
                        m_we       = (m_pick == 1) ? MEM_we : 1'b0;
                        m_addr     = (m_pick == 1) ? MEM_addr : IF_addr;
                        m_wdata    = MEM_wdata;
                    end
                end else begin
                    if (m_who == 0 && IF_cancel) m_cancel = 1;
                    m_done = 0; m_tout = 0;
                    if (M_ack) begin
                        m_done = 1;
                    end else begin
                        m_wait++;
                        if (m_wait == TMO) begin m_done = 1; m_tout = 1; end
                    end
                    if (m_done) begin
                        if (m_tout) m_err = 1;
                        if (!(m_who == 0 && m_cancel)) begin
                            m_nrdy[m_who] = 1;
                            if (m_tout)                    m_rdata[m_who] = '0;
                            else if (!(m_who == 1 && m_we)) m_rdata[m_who] = M_rdata;
                        end
                        m_who = -1;
                    end
                end
                m_rdy[0] = m_nrdy[0];
                m_rdy[1] = m_nrdy[1];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("if_ready",  32'(IF_ready),  32'(m_rdy[0]));
                chk("mem_ready", 32'(MEM_ready), 32'(m_rdy[1]));
                chk("if_rdata",  IF_rdata,  m_rdata[0]);
                chk("mem_rdata", MEM_rdata, m_rdata[1]);
                chk("m_en",      32'(M_en), 32'(m_who >= 0));
                chk("err",       32'(Err),  32'(m_err));
                chk("stall",     32'(Stall),
                    32'((IF_req && !m_rdy[0] && !IF_cancel) || (MEM_req && !m_rdy[1])));
                if (m_who >= 0) begin
                    chk("m_addr", M_addr,   m_addr);
                    chk("m_we",   32'(M_we), 32'(m_we));
                    if (m_who == 1) chk("m_wdata", M_wdata, m_wdata);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int done_q[$];
    int rdy_cyc[$];
    int stall_cnt;
    int wr_seen;

    task automatic clear_log();
        done_q.delete();
        rdy_cyc.delete();
        stall_cnt = 0;
        wr_seen   = 0;
    endtask

    // Runs until n_done completions (or budget cycles when n_done == 0),
    // dropping each request on the cycle after its ready is seen.
    task automatic run(input int n_done, input int budget);
        int   cyc;
        logic ri, rm;
        cyc = 0;
        while ((n_done == 0) || (done_q.size() < n_done)) begin
            if (cyc >= budget) begin
                if (n_done > 0) chk("run_budget", 32'(done_q.size()), 32'(n_done));
                break;
            end
            @(negedge clk);
            ri = IF_ready;
            rm = MEM_ready;
            if (Stall) stall_cnt++;
            if (M_en && M_we && M_addr == 32'h100 && M_wdata == 32'hDEADBEEF) wr_seen++;
            if (ri) begin done_q.push_back(0); rdy_cyc.push_back(cyc); end
            if (rm) begin done_q.push_back(1); rdy_cyc.push_back(cyc); end
            cyc++;
            @(posedge clk);
            #1;
            if (ri) IF_req  = 1'b0;
            if (rm) MEM_req = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish by %0t", $time);
        $fatal(1, "bench stuck");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b1; IF_req = 0; IF_addr = '0; IF_cancel = 0;
        MEM_req = 0; MEM_we = 0; MEM_addr = '0; MEM_wdata = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; chk_en = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_if_ready",  32'(IF_ready),  32'd0);
        chk("rst_mem_ready", 32'(MEM_ready), 32'd0);
        chk("rst_if_rdata",  IF_rdata,  32'd0);
        chk("rst_mem_rdata", MEM_rdata, 32'd0);
        chk("rst_m_en",      32'(M_en), 32'd0);
        chk("rst_m_we",      32'(M_we), 32'd0);
        chk("rst_m_addr",    M_addr,    32'd0);
        chk("rst_m_wdata",   M_wdata,   32'd0);
        chk("rst_err",       32'(Err),  32'd0);

        // Single fetch, ack 3 cycles after M_en rises
        @(posedge clk); #1;
        clear_log(); ack_delay = 3; IF_addr = 32'h40; IF_req = 1'b1;
        run(1, 30);
        chk("fetch_who",    32'(done_q[0]),  32'd0);
        chk("fetch_cycle",  32'(rdy_cyc[0]), 32'd5);
        chk("fetch_stall",  32'(stall_cnt),  32'd5);
        chk("fetch_rdata",  IF_rdata, 32'h8C220004);

        // Collision after reset: MEM first, then IF
        pulse_reset();
        @(posedge clk); #1;
        clear_log(); ack_delay = 1;
        IF_addr = 32'h40; MEM_addr = 32'h200; MEM_we = 1'b0;
        IF_req = 1'b1; MEM_req = 1'b1;
        run(2, 40);
        chk("tie1_first",   32'(done_q[0]),  32'd1);
        chk("tie1_second",  32'(done_q[1]),  32'd0);
        chk("tie1_cyc0",    32'(rdy_cyc[0]), 32'd3);
        chk("tie1_cyc1",    32'(rdy_cyc[1]), 32'd6);
        chk("tie1_mrdata",  MEM_rdata, 32'hA5A50200);
        chk("tie1_ifrdata", IF_rdata,  32'h8C220004);

        // MEM alone, then a tie must go to IF
        @(posedge clk); #1;
        clear_log(); MEM_req = 1'b1;
        run(1, 20);
        chk("solo_mem", 32'(done_q[0]), 32'd1);
        @(posedge clk); #1;
        clear_log(); IF_req = 1'b1; MEM_req = 1'b1;
        run(2, 40);
        chk("tie2_first",  32'(done_q[0]), 32'd0);
        chk("tie2_second", 32'(done_q[1]), 32'd1);

        // Write leaves MEM_rdata alone
        @(posedge clk); #1;
        clear_log(); ack_delay = 2;
        MEM_we = 1'b1; MEM_addr = 32'h100; MEM_wdata = 32'hDEADBEEF; MEM_req = 1'b1;
        run(1, 20);
        chk("wr_who",    32'(done_q[0]),  32'd1);
        chk("wr_cycle",  32'(rdy_cyc[0]), 32'd4);
        chk("wr_seen",   32'(wr_seen),    32'd3);
        chk("wr_rdata",  MEM_rdata, 32'hA5A50200);
        MEM_we = 1'b0; MEM_wdata = '0;

        // Cancelled fetch: no ready, IF_rdata kept
        @(posedge clk); #1;
        clear_log(); ack_delay = 4; IF_addr = 32'h80; IF_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; IF_cancel = 1'b1; IF_req = 1'b0;
        @(posedge clk); #1; IF_cancel = 1'b0;
        run(0, 10);
        chk("cancel_none",  32'(done_q.size()), 32'd0);
        chk("cancel_rdata", IF_rdata, 32'h8C220004);
        clear_log(); ack_delay = 1; IF_addr = 32'hC0; IF_req = 1'b1;
        run(1, 20);
        chk("after_cancel_who",   32'(done_q[0]), 32'd0);
        chk("after_cancel_rdata", IF_rdata, 32'hA5A500C0);

        // Timeout on a MEM read, then a normal access
        @(posedge clk); #1;
        clear_log(); ack_delay = 1000; MEM_addr = 32'h300; MEM_req = 1'b1;
        run(1, 40);
        chk("tmo_cycle", 32'(rdy_cyc[0]), 32'd16);
        chk("tmo_rdata", MEM_rdata, 32'd0);
        chk("tmo_err",   32'(Err),  32'd1);
        chk("tmo_m_en",  32'(M_en), 32'd0);
        clear_log(); ack_delay = 1; MEM_addr = 32'h200; MEM_req = 1'b1;
        run(1, 20);
        chk("post_tmo_rdata", MEM_rdata, 32'hA5A50200);
        chk("post_tmo_err",   32'(Err),  32'd1);

        // Stray ack in IDLE
        @(posedge clk); #1;
        clear_log(); stray_req = 1'b1;
        run(0, 5);
        chk("stray_none",   32'(done_q.size()), 32'd0);
        chk("stray_ifrd",   IF_rdata,  32'hA5A500C0);
        chk("stray_memrd",  MEM_rdata, 32'hA5A50200);

        // Reset mid SERVE_MEM, then a late ack
        @(posedge clk); #1;
        clear_log(); ack_delay = 1000; MEM_addr = 32'h400; MEM_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1; MEM_req = 1'b0;
        @(posedge clk); #1; rst = 1'b0; stray_req = 1'b1;
        run(0, 5);
        chk("rstmid_none",   32'(done_q.size()), 32'd0);
        chk("rstmid_m_en",   32'(M_en), 32'd0);
        chk("rstmid_m_addr", M_addr,    32'd0);
        chk("rstmid_m_we",   32'(M_we), 32'd0);
        chk("rstmid_wdata",  M_wdata,   32'd0);
        chk("rstmid_err",    32'(Err),  32'd0);
        chk("rstmid_memrd",  MEM_rdata, 32'd0);
        chk("rstmid_ifrd",   IF_rdata,  32'd0);
        chk("rstmid_mrdy",   32'(MEM_ready), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
